// File: rtl/thunderbird_lamp_monitor.sv
`default_nettype none
// ============================================================================
// Module   : thunderbird_lamp_monitor
// Purpose  : Observer/decoder for the six Thunderbird tail lamps. On every
//            controller tick it samples L = {lc,lb,la} and R = {rc,rb,ra},
//            follows the legal left / right / hazard sequences, reports the
//            active mode, counts completed sequences and sequence errors, and
//            flags a controller that stops ticking outside IDLE.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CNT_W       width of done_cnt / err_cnt (both saturate at 2^CNT_W-1)
//   STALL_CLKS  clk cycles without a tick, outside IDLE, before a stall (>= 2)
// Ports
//   clk         system clock
//   reset       asynchronous active-low reset
//   tick        one-clk strobe, controller advances its lamps in this cycle
//   la,lb,lc    left lamps, innermost to outermost
//   ra,rb,rc    right lamps, innermost to outermost
//   mode        0 idle, 1 left, 2 right, 3 hazard (registered)
//   seq_done    one-clk pulse when a full sequence returns to all-off
//   seq_err     one-clk pulse on an illegal lamp pattern at a tick
//   stall       one-clk pulse on stall timeout
//   done_cnt    completed sequences, saturating
//   err_cnt     sequence errors plus stalls, saturating
//   err_sticky  (THUNDERBIRD_MON_STICKY_EN only) latched error flag; while set
//               mode reads 0 but the sequence tracking keeps running
// Optional feature macro: THUNDERBIRD_MON_STICKY_EN
// ============================================================================
module thunderbird_lamp_monitor #(
  parameter int CNT_W      = 8,
  parameter int STALL_CLKS = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             la,
  input  logic             lb,
  input  logic             lc,
  input  logic             ra,
  input  logic             rb,
  input  logic             rc,
  output logic [1:0]       mode,
  output logic             seq_done,
  output logic             seq_err,
  output logic             stall,
  output logic [CNT_W-1:0] done_cnt,
  output logic [CNT_W-1:0] err_cnt
`ifdef THUNDERBIRD_MON_STICKY_EN
  ,
  output logic             err_sticky
`endif
);

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_L1   = 4'd1,
    ST_L2   = 4'd2,
    ST_L3   = 4'd3,
    ST_R1   = 4'd4,
    ST_R2   = 4'd5,
    ST_R3   = 4'd6,
    ST_HAZ  = 4'd7
  } state_t;

  localparam int                  c_tmr_w      = (STALL_CLKS > 2) ? $clog2(STALL_CLKS) : 1;
  // The timer value seen in the last quiet cycle before the timeout edge;
  // the edge itself would make it STALL_CLKS-1.
  localparam logic [c_tmr_w-1:0]  c_stall_last = c_tmr_w'(STALL_CLKS - 2);
  localparam logic [CNT_W-1:0]    c_cnt_max    = '1;

  state_t             r_state;
  logic [c_tmr_w-1:0] r_timer;

  logic [2:0] w_l;
  logic [2:0] w_r;
  logic       w_all_off;
  state_t     w_entry_state;
  logic       w_entry_ok;
  state_t     w_tick_state;
  logic       w_tick_done;
  logic       w_tick_err;
  logic       w_timeout;
  state_t     w_next_state;
  logic       w_done_evt;
  logic       w_err_evt;

  assign w_l       = {lc, lb, la};
  assign w_r       = {rc, rb, ra};
  assign w_all_off = (w_l == 3'b000) && (w_r == 3'b000);

  function automatic logic [1:0] mode_of(input state_t s);
    logic [1:0] m;
    m = 2'd0;
    case (s)
      ST_L1, ST_L2, ST_L3: m = 2'd1;
      ST_R1, ST_R2, ST_R3: m = 2'd2;
      ST_HAZ:              m = 2'd3;
      default:             m = 2'd0;
    endcase
    return m;
  endfunction

  // Patterns that start a sequence from IDLE. Also used to resynchronise
  // after an illegal pattern: anything not listed here lands in IDLE.
  always_comb begin
    w_entry_state = ST_IDLE;
    w_entry_ok    = 1'b0;
    if (w_l == 3'b001 && w_r == 3'b000) begin
      w_entry_state = ST_L1;
      w_entry_ok    = 1'b1;
    end else if (w_l == 3'b000 && w_r == 3'b001) begin
      w_entry_state = ST_R1;
      w_entry_ok    = 1'b1;
    end else if (w_l == 3'b111 && w_r == 3'b111) begin
      w_entry_state = ST_HAZ;
      w_entry_ok    = 1'b1;
    end
  end

  // Next state for a tick cycle. Defaults describe the error/resync path;
  // each legal step overrides them.
  always_comb begin
    w_tick_state = w_entry_state;
    w_tick_done  = 1'b0;
    w_tick_err   = 1'b1;
    case (r_state)
      ST_IDLE: begin
        // all-off keeps IDLE (entry decode already yields IDLE for it)
        if (w_all_off || w_entry_ok) begin
          w_tick_err = 1'b0;
        end
      end
      ST_L1: begin
        if (w_l == 3'b011 && w_r == 3'b000) begin
          w_tick_state = ST_L2;
          w_tick_err   = 1'b0;
        end
      end
      ST_L2: begin
        if (w_l == 3'b111 && w_r == 3'b000) begin
          w_tick_state = ST_L3;
          w_tick_err   = 1'b0;
        end
      end
      ST_R1: begin
        if (w_r == 3'b011 && w_l == 3'b000) begin
          w_tick_state = ST_R2;
          w_tick_err   = 1'b0;
        end
      end
      ST_R2: begin
        if (w_r == 3'b111 && w_l == 3'b000) begin
          w_tick_state = ST_R3;
          w_tick_err   = 1'b0;
        end
      end
      ST_L3, ST_R3, ST_HAZ: begin
        if (w_all_off) begin
          w_tick_state = ST_IDLE;
          w_tick_err   = 1'b0;
          w_tick_done  = 1'b1;
        end
      end
      default: begin
        // unreachable encodings fall back to the resync path
      end
    endcase
  end

  // A tick in the timeout cycle takes priority, so the timeout needs !tick.
  assign w_timeout = (r_state != ST_IDLE) && !tick && (r_timer == c_stall_last);

  always_comb begin
    w_next_state = r_state;
    if (tick) begin
      w_next_state = w_tick_state;
    end else if (w_timeout) begin
      w_next_state = ST_IDLE;
    end
  end

  assign w_done_evt = tick && w_tick_done;
  assign w_err_evt  = (tick && w_tick_err) || w_timeout;

`ifdef THUNDERBIRD_MON_STICKY_EN
  logic w_sticky_next;
  assign w_sticky_next = err_sticky || w_err_evt;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_timer  <= '0;
      mode     <= 2'd0;
      seq_done <= 1'b0;
      seq_err  <= 1'b0;
      stall    <= 1'b0;
      done_cnt <= '0;
      err_cnt  <= '0;
`ifdef THUNDERBIRD_MON_STICKY_EN
      err_sticky <= 1'b0;
`endif
    end else begin
      r_state  <= w_next_state;
      seq_done <= w_done_evt;
      seq_err  <= tick && w_tick_err;
      stall    <= w_timeout;

      if (tick || (r_state == ST_IDLE) || w_timeout) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + 1'b1;
      end

      if (w_done_evt && (done_cnt != c_cnt_max)) begin
        done_cnt <= done_cnt + 1'b1;
      end
      if (w_err_evt && (err_cnt != c_cnt_max)) begin
        err_cnt <= err_cnt + 1'b1;
      end

`ifdef THUNDERBIRD_MON_STICKY_EN
      err_sticky <= w_sticky_next;
      mode       <= w_sticky_next ? 2'd0 : mode_of(w_next_state);
`else
      mode       <= mode_of(w_next_state);
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_thunderbird_lamp_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_thunderbird_lamp_monitor
// Purpose  : Self-checking bench for thunderbird_lamp_monitor. Two instances
//            (CNT_W 8 and 2, both STALL_CLKS 16) share one stimulus stream;
//            a sequence-step model predicts every output each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_thunderbird_lamp_monitor;

  localparam int STALL = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tick = 1'b0;
  logic la = 1'b0, lb = 1'b0, lc = 1'b0, ra = 1'b0, rb = 1'b0, rc = 1'b0;

  logic [1:0] mode_a, mode_b;
  logic       seq_done_a, seq_err_a, stall_a;
  logic       seq_done_b, seq_err_b, stall_b;
  logic [7:0] done_cnt_a, err_cnt_a;
  logic [1:0] done_cnt_b, err_cnt_b;
`ifdef THUNDERBIRD_MON_STICKY_EN
  logic       sticky_a, sticky_b;
`endif

  always #5 clk = ~clk;

  thunderbird_lamp_monitor #(.CNT_W(8), .STALL_CLKS(STALL)) dut_a (
    .clk(clk), .reset(reset), .tick(tick),
    .la(la), .lb(lb), .lc(lc), .ra(ra), .rb(rb), .rc(rc),
    .mode(mode_a), .seq_done(seq_done_a), .seq_err(seq_err_a), .stall(stall_a),
    .done_cnt(done_cnt_a), .err_cnt(err_cnt_a)
`ifdef THUNDERBIRD_MON_STICKY_EN
    , .err_sticky(sticky_a)
`endif
  );

  thunderbird_lamp_monitor #(.CNT_W(2), .STALL_CLKS(STALL)) dut_b (
    .clk(clk), .reset(reset), .tick(tick),
    .la(la), .lb(lb), .lc(lc), .ra(ra), .rb(rb), .rc(rc),
    .mode(mode_b), .seq_done(seq_done_b), .seq_err(seq_err_b), .stall(stall_b),
    .done_cnt(done_cnt_b), .err_cnt(err_cnt_b)
`ifdef THUNDERBIRD_MON_STICKY_EN
    , .err_sticky(sticky_b)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Sequence position is family (0 idle, 1 left, 2 right, 3 hazard) plus the
  // number of lamps lit on the active side; quiet counts tickless cycles.
  int m_fam = 0, m_stp = 0, m_quiet = 0;
  int m_done_a = 0, m_err_a = 0, m_done_b = 0, m_err_b = 0;
  bit m_done = 0, m_err = 0, m_stall = 0, m_sticky = 0;

  task automatic entry(input int l, input int r, output int fam, output int stp, output bit ok);
    ok = 1; stp = 1; fam = 0;
    if (l == 1 && r == 0)      fam = 1;
    else if (l == 0 && r == 1) fam = 2;
    else if (l == 7 && r == 7) begin fam = 3; stp = 0; end
    else begin ok = 0; stp = 0; end
  endtask

  function automatic int sat(input int v, input int maxv);
    return (v < maxv) ? v + 1 : v;
  endfunction

  task automatic model_step();
    int l, r, own, oth, nf, ns;
    bit legal, ok;
    l = {lc, lb, la};
    r = {rc, rb, ra};
    m_done = 0; m_err = 0; m_stall = 0;
    if (!reset) begin
      m_fam = 0; m_stp = 0; m_quiet = 0; m_sticky = 0;
      m_done_a = 0; m_err_a = 0; m_done_b = 0; m_err_b = 0;
    end else begin
      if (tick) begin
        m_quiet = 0;
        legal = 0;
        if (m_fam == 0) begin
          entry(l, r, nf, ns, ok);
          if (ok || (l == 0 && r == 0)) begin legal = 1; m_fam = nf; m_stp = ns; end
        end else if (m_fam != 3 && m_stp < 3) begin
          own = (m_fam == 1) ? l : r;
          oth = (m_fam == 1) ? r : l;
          if (own == (1 << (m_stp + 1)) - 1 && oth == 0) begin legal = 1; m_stp++; end
        end else if (l == 0 && r == 0) begin
          legal = 1; m_done = 1; m_fam = 0; m_stp = 0;
        end
        if (!legal) begin
          m_err = 1;
          entry(l, r, nf, ns, ok);
          m_fam = nf; m_stp = ns;
        end
      end else if (m_fam != 0) begin
        m_quiet++;
        if (m_quiet == STALL - 1) begin
          m_stall = 1; m_fam = 0; m_stp = 0; m_quiet = 0;
        end
      end else begin
        m_quiet = 0;
      end
      if (m_done) begin m_done_a = sat(m_done_a, 255); m_done_b = sat(m_done_b, 3); end
      if (m_err || m_stall) begin
        m_err_a = sat(m_err_a, 255); m_err_b = sat(m_err_b, 3); m_sticky = 1;
      end
    end
  endtask

  task automatic compare_all();
    int em;
`ifdef THUNDERBIRD_MON_STICKY_EN
    em = m_sticky ? 0 : m_fam;
    chk("sticky_a", int'(sticky_a), int'(m_sticky));
    chk("sticky_b", int'(sticky_b), int'(m_sticky));
`else
    em = m_fam;
`endif
    chk("mode_a", int'(mode_a), em);
    chk("mode_b", int'(mode_b), em);
    chk("seq_done_a", int'(seq_done_a), int'(m_done));
    chk("seq_done_b", int'(seq_done_b), int'(m_done));
    chk("seq_err_a", int'(seq_err_a), int'(m_err));
    chk("seq_err_b", int'(seq_err_b), int'(m_err));
    chk("stall_a", int'(stall_a), int'(m_stall));
    chk("stall_b", int'(stall_b), int'(m_stall));
    chk("done_cnt_a", int'(done_cnt_a), m_done_a);
    chk("err_cnt_a", int'(err_cnt_a), m_err_a);
    chk("done_cnt_b", int'(done_cnt_b), m_done_b);
    chk("err_cnt_b", int'(err_cnt_b), m_err_b);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      compare_all();
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit t, input int l, input int r);
    @(negedge clk);
    tick = t;
    {lc, lb, la} = 3'(l);
    {rc, rb, ra} = 3'(r);
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) drive(0, $urandom_range(0, 7), $urandom_range(0, 7));
  endtask

  // tick with a pattern, then return in the following cycle with tick low
  task automatic do_tick(input int l, input int r);
    drive(1, l, r);
    drive(0, $urandom_range(0, 7), $urandom_range(0, 7));
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int kind, np, gap, pl, pr;
    int pats_l[4];
    int pats_r[4];

    repeat (3) @(negedge clk);
    chk("rst_mode", int'(mode_a), 0);
    chk("rst_done_cnt", int'(done_cnt_a), 0);
    chk("rst_err_cnt", int'(err_cnt_a), 0);
    reset = 1'b1;

    // left sequence
    do_tick(1, 0); chk("left1_mode", int'(mode_a), 1);
    do_tick(3, 0); chk("left2_mode", int'(mode_a), 1);
    do_tick(7, 0); chk("left3_mode", int'(mode_a), 1);
    do_tick(0, 0);
    chk("left_end_mode", int'(mode_a), 0);
    chk("left_seq_done", int'(seq_done_a), 1);
    chk("left_done_cnt", int'(done_cnt_a), 1);
    chk("left_err_cnt", int'(err_cnt_a), 0);

    // right sequence then hazard, from a fresh reset
    reset_pulse();
    do_tick(0, 1); chk("right1_mode", int'(mode_a), 2);
    do_tick(0, 3);
    do_tick(0, 7);
    do_tick(0, 0);
    do_tick(7, 7); chk("haz_mode", int'(mode_a), 3);
    do_tick(0, 0);
    chk("haz_done_cnt", int'(done_cnt_a), 2);
    chk("haz_err_cnt", int'(err_cnt_a), 0);

    // error in L2 resyncs to L1, then the sequence completes
    do_tick(1, 0);
    do_tick(3, 0);
    do_tick(1, 0);
    chk("resync_seq_err", int'(seq_err_a), 1);
    chk("resync_err_cnt", int'(err_cnt_a), 1);
`ifdef THUNDERBIRD_MON_STICKY_EN
    chk("resync_sticky", int'(sticky_a), 1);
`endif
    do_tick(3, 0);
    do_tick(7, 0);
    do_tick(0, 0);
    chk("resync_done_cnt", int'(done_cnt_a), 3);

    // stall: pulse in the 16th clk after entering L1
    do_tick(1, 0);
    quiet(14);
    chk("stall_early", int'(stall_a), 0);
    quiet(1);
    chk("stall_pulse", int'(stall_a), 1);
    chk("stall_mode", int'(mode_a), 0);
    chk("stall_err_cnt", int'(err_cnt_a), 2);

    // tick in the timeout cycle wins
    do_tick(1, 0);
    quiet(13);
    do_tick(3, 0);
    chk("tick_wins_stall", int'(stall_a), 0);
    chk("tick_wins_err_cnt", int'(err_cnt_a), 2);
    do_tick(7, 0);
    do_tick(0, 0);
    chk("tick_wins_done_cnt", int'(done_cnt_a), 4);

    // saturation of the narrow counter
    for (int i = 0; i < 5; i++) do_tick(2, 0);
    chk("sat_err_cnt_b", int'(err_cnt_b), 3);
    chk("sat_err_cnt_a", int'(err_cnt_a), 7);
    chk("sat_done_cnt_b", int'(done_cnt_b), 3);

    // asynchronous reset mid-sequence
    do_tick(1, 0);
    #2 reset = 1'b0;
    #1;
    chk("async_mode", int'(mode_a), 0);
    chk("async_done_cnt", int'(done_cnt_a), 0);
    chk("async_err_cnt", int'(err_cnt_b), 0);
    chk("async_pulses", int'({seq_done_a, seq_err_a, stall_a}), 0);
    @(negedge clk);
    reset = 1'b1;

    // randomized sequences with occasional corruption and long gaps
    for (int s = 0; s < 200; s++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        pats_l = '{1, 3, 7, 0}; pats_r = '{0, 0, 0, 0}; np = 4;
      end else if (kind == 1) begin
        pats_l = '{0, 0, 0, 0}; pats_r = '{1, 3, 7, 0}; np = 4;
      end else begin
        pats_l = '{7, 0, 0, 0}; pats_r = '{7, 0, 0, 0}; np = 2;
      end
      for (int p = 0; p < np; p++) begin
        pl = pats_l[p];
        pr = pats_r[p];
        if ($urandom_range(0, 9) == 0) begin
          pl = $urandom_range(0, 7);
          pr = $urandom_range(0, 7);
        end
        gap = ($urandom_range(0, 19) == 0) ? $urandom_range(13, 17) : $urandom_range(0, 2);
        quiet(gap);
        drive(1, pl, pr);
      end
      if ($urandom_range(0, 59) == 0) reset_pulse();
    end
    quiet(20);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
